// File: rtl/debug_pkg.sv
// debug_pkg: shared definitions for the UART debug sequencer.
//   - host command byte codes
//   - sequencer FSM state encoding
//   - HALT_WORD, the instruction word that terminates a download
package debug_pkg;

  localparam logic [7:0] CMD_START     = 8'h01;
  localparam logic [7:0] CMD_CONT      = 8'h02;
  localparam logic [7:0] CMD_STEP_MODE = 8'h03;
  localparam logic [7:0] CMD_REPROG    = 8'h05;
  localparam logic [7:0] CMD_STEP      = 8'h06;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    PROG,
    MODE,
    RUN,
    STEP_WAIT,
    STEP_EXEC,
    REPORT,
    DONE
  } seq_state_t;

endpackage

// File: rtl/report_serializer.sv
// report_serializer: sends a W-bit snapshot as W/8 bytes, MSB byte first,
// over a start/done byte handshake.
//   clk, rst  : clock, async active-high reset (aborts any transfer)
//   start     : one-cycle strobe, captures data and issues the first byte
//   data      : snapshot to send
//   tx_done   : transmitter finished the current byte
//   tx_data   : current byte, held from tx_start until tx_done
//   tx_start  : one-cycle request per byte
//   done      : one-cycle strobe after the last byte's tx_done
module report_serializer #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] data,
  input  logic         tx_done,
  output logic [7:0]   tx_data,
  output logic         tx_start,
  output logic         done
);

  localparam int NBYTES = W / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  logic [W-1:0]  shreg;
  logic [CW-1:0] left;
  logic          busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      left     <= '0;
      busy     <= 1'b0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      done     <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      if (start) begin
        tx_data  <= data[W-1 -: 8];
        shreg    <= data << 8;
        left     <= CW'(NBYTES - 1);
        tx_start <= 1'b1;
        busy     <= 1'b1;
      end else if (busy && tx_done) begin
        if (left == '0) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          // next byte goes out the cycle after the previous one completed
          tx_data  <= shreg[W-1 -: 8];
          shreg    <= shreg << 8;
          left     <= left - CW'(1);
          tx_start <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/debug_sequencer.sv
// debug_sequencer: UART-driven loader and run controller for a pipeline.
// Host downloads a program word by word (MSB byte first), then selects
// free-running or single-step execution; after each stop the PC and the
// enabled-cycle count are reported back as 8 bytes.
//   CLK100MHZ, SWITCH_RESET : clock, async active-high reset
//   rx_data/rx_done         : received byte + strobe
//   tx_data/tx_start/tx_done: transmit byte handshake
//   halt, pc                : pipeline status
//   cpu_enable, cpu_reset   : pipeline clock-enable and sync reset pulse
//   imem_*                  : instruction memory write port
module debug_sequencer
  import debug_pkg::*;
#(
  parameter int LEN      = 32,
  parameter int ADDR_LEN = 10
) (
  input  logic                CLK100MHZ,
  input  logic                SWITCH_RESET,
  input  logic [7:0]          rx_data,
  input  logic                rx_done,
  output logic [7:0]          tx_data,
  output logic                tx_start,
  input  logic                tx_done,
  input  logic                halt,
  input  logic [LEN-1:0]      pc,
  output logic                cpu_enable,
  output logic                cpu_reset,
  output logic                imem_wr_en,
  output logic [ADDR_LEN-1:0] imem_addr,
  output logic [LEN-1:0]      imem_wr_data
);

  localparam int NB  = LEN / 8;
  localparam int BCW = (NB > 1) ? $clog2(NB) : 1;

  seq_state_t     state;
  logic [BCW-1:0] byte_cnt;
  logic [LEN-1:0] word;
  logic [LEN-1:0] next_word;
  logic [LEN-1:0] cycle_count;
  logic           halt_flag;
  logic           addr_inc;
  logic           rep_go;
  logic           rep_done;

  assign next_word = {word[LEN-9:0], rx_data};

  // halt gates the enable in the same cycle so no extra instruction issues
  assign cpu_enable = (state == RUN || state == STEP_EXEC) && !halt;

  always_ff @(posedge CLK100MHZ or posedge SWITCH_RESET) begin
    if (SWITCH_RESET) begin
      state        <= IDLE;
      cpu_reset    <= 1'b1;
      imem_wr_en   <= 1'b0;
      imem_addr    <= '0;
      imem_wr_data <= '0;
      word         <= '0;
      byte_cnt     <= '0;
      cycle_count  <= '0;
      halt_flag    <= 1'b0;
      addr_inc     <= 1'b0;
      rep_go       <= 1'b0;
    end else begin
      cpu_reset  <= 1'b0;
      imem_wr_en <= 1'b0;
      addr_inc   <= 1'b0;
      rep_go     <= 1'b0;

      if (cpu_reset)
        cycle_count <= '0;
      else if (cpu_enable && cycle_count != '1)
        cycle_count <= cycle_count + LEN'(1);

      // address advances after the write strobe, so the strobe sees the old one
      if (addr_inc)
        imem_addr <= imem_addr + ADDR_LEN'(1);

      case (state)
        IDLE, DONE: begin
          if (rx_done && rx_data == ((state == IDLE) ? CMD_START : CMD_REPROG)) begin
            state     <= PROG;
            cpu_reset <= 1'b1;
            imem_addr <= '0;
            byte_cnt  <= '0;
            word      <= '0;
            halt_flag <= 1'b0;
          end
        end
        PROG: begin
          if (rx_done) begin
            word     <= next_word;
            byte_cnt <= byte_cnt + BCW'(1);
            if (byte_cnt == BCW'(NB - 1)) begin
              byte_cnt     <= '0;
              imem_wr_en   <= 1'b1;
              imem_wr_data <= next_word;
              // last slot of memory also ends the download: never wrap
              if (next_word == LEN'(HALT_WORD) || imem_addr == '1)
                state <= MODE;
              else
                addr_inc <= 1'b1;
            end
          end
        end
        MODE: begin
          if (rx_done) begin
            if (rx_data == CMD_CONT)           state <= RUN;
            else if (rx_data == CMD_STEP_MODE) state <= STEP_WAIT;
          end
        end
        RUN: begin
          if (halt) begin
            halt_flag <= 1'b1;
            state     <= REPORT;
            rep_go    <= 1'b1;
          end
        end
        STEP_WAIT: begin
          if (rx_done && rx_data == CMD_STEP)
            state <= STEP_EXEC;
        end
        STEP_EXEC: begin
          if (halt)
            halt_flag <= 1'b1;
          state  <= REPORT;
          rep_go <= 1'b1;
        end
        REPORT: begin
          if (rep_done)
            state <= halt_flag ? DONE : STEP_WAIT;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Snapshot is taken in the first REPORT cycle, so the count already
  // includes the step executed in STEP_EXEC.
  report_serializer #(.W(2 * LEN)) u_ser (
    .clk      (CLK100MHZ),
    .rst      (SWITCH_RESET),
    .start    (rep_go),
    .data     ({pc, cycle_count}),
    .tx_done  (tx_done),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .done     (rep_done)
  );

endmodule

// File: tb/tb_debug_sequencer.sv
module tb_debug_sequencer;

  localparam int AW = 4;
  localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

  logic          clk;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_done;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_done;
  logic          halt;
  logic [31:0]   pc;
  logic          cpu_enable;
  logic          cpu_reset;
  logic          imem_wr_en;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wr_data;

  debug_sequencer #(.LEN(32), .ADDR_LEN(AW)) dut (
    .CLK100MHZ    (clk),
    .SWITCH_RESET (rst),
    .rx_data      (rx_data),
    .rx_done      (rx_done),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .tx_done      (tx_done),
    .halt         (halt),
    .pc           (pc),
    .cpu_enable   (cpu_enable),
    .cpu_reset    (cpu_reset),
    .imem_wr_en   (imem_wr_en),
    .imem_addr    (imem_addr),
    .imem_wr_data (imem_wr_data)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [35:0] wq[$];
  logic [7:0]  txq[$];
  logic [31:0] prog[$];
  int en_cnt = 0;
  int en_tot = 0;
  int rstc = 0;
  int halt_after = 1000;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // observers: sampled on the falling edge, away from the active edge
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (imem_wr_en) wq.push_back({imem_addr, imem_wr_data});
      if (tx_start)   txq.push_back(tx_data);
      if (cpu_enable) begin en_cnt++; en_tot++; end
      if (cpu_reset)  begin en_cnt = 0; rstc++; end
    end
  end

  // pipeline model: halts once it has been enabled halt_after cycles
  initial begin
    halt = 1'b0;
    forever begin
      @(posedge clk); #1;
      halt = (en_cnt >= halt_after);
    end
  end

  // UART transmitter model with random byte time
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 tx_done = 1'b1;
        @(posedge clk);
        #1 tx_done = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick(2 + int'($urandom_range(0, 2)));
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send(w[8*i +: 8]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    chk("rst_tx_start",   64'(tx_start),     64'(0));
    chk("rst_imem_wr_en", 64'(imem_wr_en),   64'(0));
    chk("rst_cpu_enable", 64'(cpu_enable),   64'(0));
    chk("rst_cpu_reset",  64'(cpu_reset),    64'(1));
    chk("rst_tx_data",    64'(tx_data),      64'(0));
    chk("rst_imem_addr",  64'(imem_addr),    64'(0));
    chk("rst_wr_data",    64'(imem_wr_data), 64'(0));
    rst = 1'b0;
    tick(2);
    wq = {}; txq = {};
    en_cnt = 0; en_tot = 0; rstc = 0;
  endtask

  // expected writes: one per word from addr 0, stopping at the halt word
  // or at the last memory slot
  task automatic load_prog(input logic [7:0] cmd);
    logic [35:0] exp_w[$];
    exp_w = {};
    for (int i = 0; i < prog.size(); i++) begin
      exp_w.push_back({AW'(i), prog[i]});
      if (prog[i] == HALTW || i == (1 << AW) - 1) break;
    end
    rstc = 0;
    wq = {};
    send(cmd);
    foreach (prog[i]) send_word(prog[i]);
    tick(4);
    chk("cpu_reset_cycles", 64'(rstc), 64'(1));
    chk("wr_count", 64'(wq.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < wq.size(); i++)
      chk("wr_addr_data", 64'(wq[i]), 64'(exp_w[i]));
    wq = {};
  endtask

  task automatic wait_tx(input int n);
    int t = 0;
    while (txq.size() < n && t < 1000) begin tick(); t++; end
    chk("tx_bytes_seen", 64'(txq.size()), 64'(n));
    tick(10);
  endtask

  task automatic check_report(input logic [31:0] pcv, input logic [31:0] cyc);
    logic [63:0] exp;
    exp = {pcv, cyc};
    for (int i = 0; i < 8 && i < txq.size(); i++)
      chk("tx_byte", 64'(txq[i]), 64'(exp[63 - 8*i -: 8]));
    txq = {};
  endtask

  task automatic do_run(input int k, input logic [31:0] pcv);
    halt_after = k;
    pc = pcv;
    en_tot = 0;
    txq = {};
    send(8'h02);
    wait_tx(8);
    check_report(pcv, 32'(k));
    chk("run_en_cycles", 64'(en_tot), 64'(k));
  endtask

  task automatic do_step(input int n);
    logic [31:0] pcv;
    halt_after = 1000;
    en_tot = 0;
    txq = {};
    send(8'h03);
    send(8'h02);
    send(8'h04);
    tick(10);
    chk("step_wait_en", 64'(en_tot), 64'(0));
    chk("step_wait_tx", 64'(txq.size()), 64'(0));
    for (int s = 1; s <= n; s++) begin
      pcv = $urandom();
      pc = pcv;
      send(8'h06);
      wait_tx(8);
      check_report(pcv, 32'(s));
      chk("step_en_cycles", 64'(en_tot), 64'(s));
    end
    // pipeline now halted: a step must not enable it and ends the session
    halt_after = n;
    tick(2);
    pcv = $urandom();
    pc = pcv;
    send(8'h06);
    wait_tx(8);
    check_report(pcv, 32'(n));
    chk("halted_step_en", 64'(en_tot), 64'(n));
  endtask

  task automatic rand_prog(input int len);
    logic [31:0] w;
    prog = {};
    for (int j = 0; j < len - 1; j++) begin
      w = $urandom();
      if (w == HALTW) w = 32'h0;
      prog.push_back(w);
    end
    prog.push_back(HALTW);
  endtask

  initial begin
    rst = 1'b1;
    rx_data = '0;
    rx_done = 1'b0;
    pc = '0;
    do_reset();

    // directed download
    prog = {32'h2008_0005, HALTW};
    load_prog(8'h01);

    // free run, halt after 5 enabled cycles
    do_run(5, 32'h0000_000C);

    // DONE ignores everything except reprogram
    txq = {}; wq = {}; rstc = 0; en_tot = 0;
    send(8'h06);
    send(8'h01);
    send(8'h02);
    tick(10);
    chk("done_ignore_tx", 64'(txq.size()), 64'(0));
    chk("done_ignore_wr", 64'(wq.size()), 64'(0));
    chk("done_ignore_rst", 64'(rstc), 64'(0));
    chk("done_ignore_en", 64'(en_tot), 64'(0));

    // reprogram clears the count; then single-step session
    rand_prog(3);
    load_prog(8'h05);
    do_step(2);

    // reset in the middle of a word discards it
    do_reset();
    send(8'h01);
    send(8'hAB);
    send(8'hCD);
    do_reset();
    chk("abort_no_write", 64'(wq.size()), 64'(0));

    // fill every slot without a halt word: download must end at the top
    prog = {};
    for (int i = 0; i < (1 << AW); i++) begin
      logic [31:0] w;
      w = $urandom();
      if (w == HALTW) w = 32'h1;
      prog.push_back(w);
    end
    load_prog(8'h01);
    do_run(int'($urandom_range(1, 20)), $urandom());

    // randomized sessions
    for (int it = 0; it < 6; it++) begin
      rand_prog(int'($urandom_range(1, 5)));
      load_prog(8'h05);
      send(($urandom_range(0, 1) != 0) ? 8'h05 : 8'h06);
      if ($urandom_range(0, 1) != 0)
        do_run(int'($urandom_range(1, 25)), $urandom());
      else
        do_step(int'($urandom_range(1, 3)));
    end

    // reset in the middle of a report stops transmission
    do_reset();
    prog = {HALTW};
    load_prog(8'h01);
    halt_after = 3;
    pc = $urandom();
    txq = {};
    send(8'h02);
    begin
      int t = 0;
      while (txq.size() < 3 && t < 500) begin tick(); t++; end
    end
    chk("mid_report_started", 64'(txq.size() >= 3), 64'(1));
    do_reset();
    tick(50);
    chk("post_reset_tx", 64'(txq.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
